// File: rtl/egress_filtering.sv
// Egress filter: buffers each packet's Ethernet header, decides forward/drop from
// source-MAC, etype and runt checks, then flushes the header and passes the tail or sinks it.
//   state    | meaning
//   S_HDR    | collect header beats into hdr_buf
//   S_DECIDE | one-cycle verdict on the buffered header
//   S_FLUSH  | replay buffered header beats downstream
//   S_PASS   | zero-latency passthrough of the remaining beats
//   S_DROP   | discard the rest of the packet
module egress_filtering #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXIS_BUS_WIDTH-1:0]              axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]            axis_in_tkeep,
  input  logic [AXIS_ID_WIDTH-1:0]               axis_in_tid,
  input  logic                                   axis_in_tlast,
  input  logic                                   axis_in_tvalid,
  output logic                                   axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]            axis_out_tkeep,
  output logic [AXIS_ID_WIDTH-1:0]               axis_out_tid,
  output logic                                   axis_out_tlast,
  output logic                                   axis_out_tvalid,
  input  logic                                   axis_out_tready,
  input  logic [(2**AXIS_ID_WIDTH)*48-1:0]       mac_table,
  input  logic [(2**AXIS_ID_WIDTH)-1:0]          mac_check_en,
  input  logic                                   block_config,
  input  logic [15:0]                            config_etype,
  output logic                                   drop_pulse,
  output logic [31:0]                            drop_count
);
  localparam int NB        = AXIS_BUS_WIDTH / 8;
  localparam int HDR_BEATS = (14 + NB - 1) / NB;
  localparam int CW        = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int PCW       = $clog2(HDR_BEATS * NB + 1);

  typedef enum logic [2:0] {S_HDR, S_DECIDE, S_FLUSH, S_PASS, S_DROP} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             last_idx_q, last_idx_d;
  logic [AXIS_ID_WIDTH-1:0]  tid_q, tid_d;
  logic                      drop_pulse_q, drop_pulse_d;
  logic [31:0]               drop_count_q, drop_count_d;
  logic [AXIS_BUS_WIDTH-1:0] hdr_data_q [HDR_BEATS];
  logic [AXIS_BUS_WIDTH-1:0] hdr_data_d [HDR_BEATS];
  logic [NB-1:0]             hdr_keep_q [HDR_BEATS];
  logic [NB-1:0]             hdr_keep_d [HDR_BEATS];
  logic [HDR_BEATS-1:0]      hdr_last_q, hdr_last_d;

  logic [47:0]    src_mac;
  logic [15:0]    etype;
  logic [PCW-1:0] keep_cnt;
  logic           is_runt, mac_bad, etype_hit, drop_v;

  // Header bytes are picked from fixed lanes, so this reduces to wiring.
  always_comb begin
    src_mac = '0;
    etype   = '0;
    for (int i = 0; i < 6; i++) begin
      src_mac[8*(5-i) +: 8] = hdr_data_q[(6+i)/NB][8*((6+i)%NB) +: 8];
    end
    etype[15:8] = hdr_data_q[12/NB][8*(12%NB) +: 8];
    etype[7:0]  = hdr_data_q[13/NB][8*(13%NB) +: 8];
    keep_cnt = '0;
    for (int k = 0; k < HDR_BEATS; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (CW'(k) <= last_idx_q && hdr_keep_q[k][b]) keep_cnt = keep_cnt + PCW'(1);
      end
    end
  end

  assign is_runt   = keep_cnt < PCW'(14);
  assign mac_bad   = mac_check_en[tid_q] && (src_mac != mac_table[48*int'(tid_q) +: 48]);
  assign etype_hit = block_config && (etype == config_etype);
  assign drop_v    = is_runt || mac_bad || etype_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_idx_d   = last_idx_q;
    tid_d        = tid_q;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;
    hdr_data_d   = hdr_data_q;
    hdr_keep_d   = hdr_keep_q;
    hdr_last_d   = hdr_last_q;

    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tdata  = hdr_data_q[cnt_q];
    axis_out_tkeep  = hdr_keep_q[cnt_q];
    axis_out_tlast  = hdr_last_q[cnt_q];

    case (state_q)
      S_HDR: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid) begin
          hdr_data_d[cnt_q] = axis_in_tdata;
          hdr_keep_d[cnt_q] = axis_in_tkeep;
          hdr_last_d[cnt_q] = axis_in_tlast;
          if (cnt_q == '0) tid_d = axis_in_tid;
          if (axis_in_tlast || cnt_q == CW'(HDR_BEATS-1)) begin
            last_idx_d = cnt_q;
            cnt_d      = '0;
            state_d    = S_DECIDE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DECIDE: begin
        if (drop_v) begin
          state_d      = S_DROP;
          drop_pulse_d = 1'b1;
          if (drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        axis_out_tvalid = 1'b1;
        if (axis_out_tready) begin
          if (cnt_q == last_idx_q) begin
            cnt_d   = '0;
            state_d = hdr_last_q[cnt_q] ? S_HDR : S_PASS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_PASS: begin
        axis_out_tdata  = axis_in_tdata;
        axis_out_tkeep  = axis_in_tkeep;
        axis_out_tlast  = axis_in_tlast;
        axis_out_tvalid = axis_in_tvalid;
        axis_in_tready  = axis_out_tready;
        if (axis_in_tvalid && axis_out_tready && axis_in_tlast) state_d = S_HDR;
      end
      S_DROP: begin
        // A tlast already in the buffer means nothing of this packet is left upstream.
        if (hdr_last_q[last_idx_q]) begin
          state_d = S_HDR;
        end else begin
          axis_in_tready = 1'b1;
          if (axis_in_tvalid && axis_in_tlast) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    if (areset) begin
      axis_in_tready  = 1'b0;
      axis_out_tvalid = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_HDR;
      cnt_q        <= '0;
      last_idx_q   <= '0;
      tid_q        <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_idx_q   <= last_idx_d;
      tid_q        <= tid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge aclk) begin
    hdr_data_q <= hdr_data_d;
    hdr_keep_q <= hdr_keep_d;
    hdr_last_q <= hdr_last_d;
  end

  assign axis_out_tid = tid_q;
  assign drop_pulse   = drop_pulse_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_egress_filtering.sv
// Directed frame table plus hand sequences (latency, back-to-back, reset) and a
// random pass/drop stress run with stalls, checked against hand-derived expectations.
module tb_egress_filtering;
  localparam int W = 64, NB = 8, IDW = 4, NID = 16;

  logic aclk = 1'b0;
  logic areset;
  logic [W-1:0] in_tdata;
  logic [NB-1:0] in_tkeep;
  logic [IDW-1:0] in_tid;
  logic in_tlast, in_tvalid, in_tready;
  logic [W-1:0] out_tdata;
  logic [NB-1:0] out_tkeep;
  logic [IDW-1:0] out_tid;
  logic out_tlast, out_tvalid;
  logic out_tready = 1'b1;
  logic [NID*48-1:0] mac_table;
  logic [NID-1:0] mac_check_en;
  logic block_config;
  logic [15:0] config_etype;
  logic drop_pulse;
  logic [31:0] drop_count;

  always #5 aclk = ~aclk;

  egress_filtering #(.AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW)) dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tid(in_tid),
    .axis_in_tlast(in_tlast), .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tid(out_tid),
    .axis_out_tlast(out_tlast), .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
    .mac_table(mac_table), .mac_check_en(mac_check_en), .block_config(block_config),
    .config_etype(config_etype), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  typedef struct {
    int          len;
    logic [3:0]  tid;
    logic [47:0] src;
    logic [15:0] et;
    logic        en;
    logic        blk;
    logic [15:0] cfg;
    logic        exp_drop;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  int out_frames = 0, pulses = 0, beats_acc = 0;
  int t_in = 0, t_out = 0;
  bit seen_out = 0;
  bit rand_ready = 0;
  logic hold_ready = 1'b1;
  logic [7:0] out_bytes[$];
  logic [3:0] tid_seen[$];
  logic [7:0] fb[$];
  logic [7:0] exp_q[$];
  int acc_cyc[$];

  function automatic logic [47:0] mac(input int i);
    return 48'h020000000000 | 48'(i);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc++;

  initial forever begin
    @(posedge aclk); #1;
    out_tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
  end

  logic [W-1:0] pd;
  logic [NB-1:0] pk;
  logic pl;
  logic [3:0] pt;
  bit stall_prev = 0;
  always @(negedge aclk) begin
    if (areset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && out_tvalid) begin
        checks++;
        if ({out_tdata, out_tkeep, out_tlast, out_tid} != {pd, pk, pl, pt}) begin
          failures++;
          $display("FAIL stable_while_stalled actual=%h required=%h", out_tdata, pd);
        end
      end
      if (out_tvalid && !seen_out) begin seen_out = 1; t_out = cyc; end
      if (out_tvalid && out_tready) begin
        for (int l = 0; l < NB; l++) if (out_tkeep[l]) out_bytes.push_back(out_tdata[8*l +: 8]);
        tid_seen.push_back(out_tid);
        if (out_tlast) out_frames++;
      end
      if (drop_pulse) pulses++;
      stall_prev = out_tvalid && !out_tready;
      pd = out_tdata; pk = out_tkeep; pl = out_tlast; pt = out_tid;
    end
  end

  task automatic build(input int len, input logic [47:0] src, input logic [15:0] et, input int seed);
    logic [7:0] v;
    fb.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) v = 8'hA0 + 8'(i);
      else if (i < 12) v = src[8*(11-i) +: 8];
      else if (i == 12) v = et[15:8];
      else if (i == 13) v = et[7:0];
      else v = 8'(i * 7 + seed);
      fb.push_back(v);
    end
  endtask

  task automatic wait_ready(input bit first);
    int n = 0;
    @(negedge aclk);
    while (!in_tready && n < 1000) begin n++; @(negedge aclk); end
    if (!in_tready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      if (first) t_in = cyc;
      acc_cyc.push_back(cyc);
      beats_acc++;
    end
    @(posedge aclk); #1;
  endtask

  task automatic send(input logic [3:0] tid, input bit gaps);
    int nbt;
    logic [W-1:0] d;
    logic [NB-1:0] k;
    nbt = (fb.size() + NB - 1) / NB;
    for (int b = 0; b < nbt; b++) begin
      d = '0; k = '0;
      for (int l = 0; l < NB; l++) if (b*NB + l < fb.size()) begin d[8*l +: 8] = fb[b*NB + l]; k[l] = 1'b1; end
      if (gaps) while ($urandom_range(0, 3) == 0) begin in_tvalid = 1'b0; @(posedge aclk); #1; end
      in_tdata = d; in_tkeep = k; in_tlast = (b == nbt - 1);
      in_tid = (b == 0) ? tid : 4'($urandom_range(0, 15));
      in_tvalid = 1'b1;
      wait_ready(b == 0);
      in_tvalid = 1'b0;
    end
  endtask

  task automatic drain(input int exp_frames);
    int n = 0;
    while (out_frames < exp_frames && n < 5000) begin @(posedge aclk); #1; n++; end
    repeat (4) begin @(posedge aclk); #1; end
  endtask

  task automatic clear_mon();
    out_bytes.delete(); tid_seen.delete(); acc_cyc.delete();
    out_frames = 0; beats_acc = 0; seen_out = 0;
  endtask

  task automatic compare_out(input string tag, input logic [3:0] tid);
    int bad = 0, badt = 0;
    check({tag, "_out_bytes"}, out_bytes.size(), exp_q.size());
    if (exp_q.size() != 0) begin
      for (int i = 0; i < out_bytes.size() && i < exp_q.size(); i++) if (out_bytes[i] != exp_q[i]) bad++;
      foreach (tid_seen[i]) if (tid_seen[i] != tid) badt++;
      check({tag, "_data"}, bad, 0);
      check({tag, "_out_tid"}, badt, 0);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx, input bit gaps);
    longint dc0;
    int p0;
    string tag;
    tag = $sformatf("f%0d", idx);
    dc0 = longint'(drop_count);
    p0 = pulses;
    clear_mon();
    mac_check_en = '0;
    mac_check_en[v.tid] = v.en;
    block_config = v.blk;
    config_etype = v.cfg;
    build(v.len, v.src, v.et, idx);
    exp_q.delete();
    if (!v.exp_drop) exp_q = fb;
    send(v.tid, gaps);
    drain(v.exp_drop ? 0 : 1);
    check({tag, "_beats_in"}, beats_acc, (v.len + 7) / 8);
    check({tag, "_drop_count"}, longint'(drop_count) - dc0, longint'(v.exp_drop));
    check({tag, "_drop_pulses"}, pulses - p0, int'(v.exp_drop));
    compare_out(tag, v.tid);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = '{64, 4'd3,  mac(3),  16'h0800, 1'b1, 1'b0, 16'h88B5, 1'b0};
    tbl[1]  = '{64, 4'd3,  mac(4),  16'h0800, 1'b1, 1'b0, 16'h88B5, 1'b1};
    tbl[2]  = '{64, 4'd3,  mac(4),  16'h0800, 1'b0, 1'b0, 16'h88B5, 1'b0};
    tbl[3]  = '{64, 4'd5,  mac(5),  16'h88B5, 1'b0, 1'b1, 16'h88B5, 1'b1};
    tbl[4]  = '{64, 4'd5,  mac(5),  16'h88B5, 1'b0, 1'b0, 16'h88B5, 1'b0};
    tbl[5]  = '{10, 4'd2,  mac(2),  16'h0800, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[6]  = '{16, 4'd2,  mac(2),  16'h0800, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{14, 4'd1,  mac(1),  16'h0800, 1'b1, 1'b1, 16'h88B5, 1'b0};
    tbl[8]  = '{13, 4'd1,  mac(1),  16'h0800, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[9]  = '{8,  4'd0,  mac(0),  16'h0800, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[10] = '{70, 4'd15, mac(15), 16'h1235, 1'b1, 1'b1, 16'h1234, 1'b0};
    tbl[11] = '{20, 4'd7,  mac(7),  16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1};

    for (int i = 0; i < NID; i++) mac_table[48*i +: 48] = mac(i);
    mac_check_en = '0; block_config = 1'b0; config_etype = '0;
    in_tdata = '0; in_tkeep = '0; in_tid = '0; in_tlast = 1'b0; in_tvalid = 1'b1;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    @(posedge aclk); #1;
    areset = 1'b0; in_tvalid = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i], i, 1'b0);
      if (i == 0) check("latency_first_out", t_out - t_in, 3);
    end

    // back-to-back: 24B frame then 16B frame, second beat 0 accepted the cycle after tlast
    clear_mon();
    mac_check_en = '0; block_config = 1'b0;
    build(24, mac(6), 16'h0800, 40);
    exp_q = fb;
    send(4'd6, 1'b0);
    build(16, mac(6), 16'h0801, 41);
    foreach (fb[i]) exp_q.push_back(fb[i]);
    send(4'd6, 1'b0);
    drain(2);
    check("b2b_frames", out_frames, 2);
    check("b2b_gap", acc_cyc[3] - acc_cyc[2], 1);
    check("b2b_pass_beat", acc_cyc[2] - acc_cyc[0], 5);
    compare_out("b2b", 4'd6);

    // reset during beat 4 of a passing frame
    clear_mon();
    build(64, mac(3), 16'h0800, 50);
    for (int b = 0; b < 4; b++) begin
      for (int l = 0; l < NB; l++) in_tdata[8*l +: 8] = fb[b*NB + l];
      in_tkeep = '1; in_tlast = 1'b0; in_tid = 4'd3; in_tvalid = 1'b1;
      wait_ready(b == 0);
    end
    for (int l = 0; l < NB; l++) in_tdata[8*l +: 8] = fb[4*NB + l];
    areset = 1'b1;
    @(negedge aclk);
    check("midrst_out_tvalid", out_tvalid, 0);
    check("midrst_in_tready", in_tready, 0);
    @(posedge aclk); #1;
    areset = 1'b0; in_tvalid = 1'b0;
    @(negedge aclk);
    check("postrst_out_tvalid", out_tvalid, 0);
    check("postrst_drop_count", drop_count, 0);
    @(posedge aclk); #1;
    run_frame(tbl[0], 100, 1'b0);

    // random stress with input gaps and 50% output ready
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      rv.len = $urandom_range(6, 72);
      rv.tid = 4'($urandom_range(0, 15));
      rv.src = ($urandom_range(0, 3) == 0) ? mac(int'(rv.tid) ^ 1) : mac(int'(rv.tid));
      rv.et  = ($urandom_range(0, 1) == 1) ? 16'h88B5 : 16'h0800;
      rv.cfg = ($urandom_range(0, 1) == 1) ? 16'h88B5 : 16'h0800;
      rv.en  = 1'($urandom_range(0, 1));
      rv.blk = 1'($urandom_range(0, 1));
      rv.exp_drop = (rv.len < 14) || (rv.en && rv.src != mac(int'(rv.tid))) ||
                    (rv.blk && rv.et == rv.cfg);
      run_frame(rv, 200 + n, 1'b1);
    end
    rand_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
